ddr_burst_reader: RTL and testbench

Bus-master read engine between `fill_fifo_fsm` and the HDMI pixel FIFO in `hdmi_out`. Each `go_fill_fifo` pulse with its `ddr_addr_to_read` becomes one fixed-length DDR read burst. Returned words are written into the pixel FIFO with back-pressure. One request queues behind an active burst, and status is reported to the software slave registers.

---
 rtl/hdmi_out_pkg.sv | 26 ++
 rtl/req_pending_slot.sv | 61 ++++++
 rtl/ddr_burst_reader.sv | 186 ++++++++++++++++++
 tb/tb_ddr_burst_reader.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_out_pkg.sv
// -----------------------------------------------------------------------------
// hdmi_out_pkg
//   Definitions shared by the HDMI output fill path (fill_fifo_fsm,
//   ddr_burst_reader, req_pending_slot).
//   - fill_state_t    : 2-bit burst-engine state encoding
//   - BURST_WORDS_DEF : default burst length in 32-bit words (half the pixel FIFO)
//   - BYTES_PER_WORD  : bytes per bus word
//   - align_word()    : clears the byte-offset bits of a byte address
// -----------------------------------------------------------------------------
package hdmi_out_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } fill_state_t;

    localparam int BURST_WORDS_DEF = 64;
    localparam int BYTES_PER_WORD  = 4;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/req_pending_slot.sv
// -----------------------------------------------------------------------------
// req_pending_slot
//   One-deep holding register for a burst request that arrives while the
//   reader is busy. Push and pop in the same cycle replace the held entry,
//   so a live request can move in as the held one is dispatched.
//   Ports:
//     clk_i, rst_i   : clock, asynchronous active-high reset (clears valid)
//     push_i         : offer a request to the slot
//     push_addr_i    : address of the offered request
//     pop_i          : held request is being dispatched this cycle
//     vld_o, addr_o  : held request
//     overrun_o      : offered request dropped because the slot is occupied
// -----------------------------------------------------------------------------
module req_pending_slot
    import hdmi_out_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic              pop_i,
    output logic              vld_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              overrun_o
);

    logic              vld_q, vld_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        vld_d     = vld_q;
        addr_d    = addr_q;
        overrun_o = push_i && vld_q && !pop_i;
        if (pop_i) begin
            vld_d = 1'b0;
        end
        if (push_i && (!vld_q || pop_i)) begin
            vld_d  = 1'b1;
            addr_d = push_addr_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Address is only meaningful while vld_q is set, so it needs no reset.
    always_ff @(posedge clk_i) begin
        addr_q <= addr_d;
    end

    assign vld_o  = vld_q;
    assign addr_o = addr_q;

endmodule

// File: rtl/ddr_burst_reader.sv
// -----------------------------------------------------------------------------
// ddr_burst_reader
//   Turns each go_fill_fifo strobe into one fixed-length DDR read burst and
//   streams the returned words into the HDMI pixel FIFO with back-pressure.
//   One further request can wait behind an active burst.
//   Ports:
//     Bus2IP_Clk, Bus2IP_Reset          : clock, async active-high reset
//     go_fill_fifo, ddr_addr_to_read    : burst request strobe + byte address
//     clr_status                        : clears the sticky status flags
//     rd_req, rd_addr, rd_len, rd_ack   : read command handshake
//     rd_data, rd_data_valid,
//     rd_data_ready                     : read data beats
//     rd_cmplt, rd_error                : end of burst, with failure flag
//     fifo_wr_en, fifo_wr_data,
//     fifo_full                         : pixel FIFO write port
//     busy                              : not IDLE
//     err_sticky                        : bus error or wrong beat count seen
//     overrun_sticky                    : a request was dropped
// -----------------------------------------------------------------------------
module ddr_burst_reader
    import hdmi_out_pkg::*;
#(
    parameter int BURST_WORDS = BURST_WORDS_DEF,
    parameter int DATA_W      = 32
) (
    input  logic              Bus2IP_Clk,
    input  logic              Bus2IP_Reset,
    input  logic              go_fill_fifo,
    input  logic [31:0]       ddr_addr_to_read,
    input  logic              clr_status,
    output logic              rd_req,
    output logic [31:0]       rd_addr,
    output logic [11:0]       rd_len,
    input  logic              rd_ack,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_data_valid,
    output logic              rd_data_ready,
    input  logic              rd_cmplt,
    input  logic              rd_error,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    input  logic              fifo_full,
    output logic              busy,
    output logic              err_sticky,
    output logic              overrun_sticky
);

    localparam int               CNT_W     = $clog2(BURST_WORDS) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(BURST_WORDS);
    localparam logic [11:0]      LEN_BYTES = 12'(BURST_WORDS * BYTES_PER_WORD);

    fill_state_t      state_q, state_d;
    logic [31:0]      rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0] cnt_after;
    logic             err_q, err_d;
    logic             ovr_q, ovr_d;
    logic             err_set;
    logic             beat_acc;

    logic             slot_push;
    logic             slot_pop;
    logic             slot_vld;
    logic [31:0]      slot_addr;
    logic             slot_overrun;

    req_pending_slot #(
        .ADDR_W (32)
    ) u_slot (
        .clk_i       (Bus2IP_Clk),
        .rst_i       (Bus2IP_Reset),
        .push_i      (slot_push),
        .push_addr_i (ddr_addr_to_read),
        .pop_i       (slot_pop),
        .vld_o       (slot_vld),
        .addr_o      (slot_addr),
        .overrun_o   (slot_overrun)
    );

    always_comb begin
        state_d       = state_q;
        rd_addr_d     = rd_addr_q;
        beat_cnt_d    = beat_cnt_q;
        cnt_after     = beat_cnt_q;
        rd_req        = 1'b0;
        rd_data_ready = 1'b0;
        fifo_wr_en    = 1'b0;
        fifo_wr_data  = '0;
        slot_push     = 1'b0;
        slot_pop      = 1'b0;
        err_set       = 1'b0;
        beat_acc      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A held request goes first; a live strobe in the same cycle
                // takes its place in the slot.
                if (slot_vld) begin
                    slot_pop  = 1'b1;
                    slot_push = go_fill_fifo;
                    rd_addr_d = align_word(slot_addr);
                    state_d   = ST_REQ;
                end else if (go_fill_fifo) begin
                    rd_addr_d = align_word(ddr_addr_to_read);
                    state_d   = ST_REQ;
                end
            end

            ST_REQ: begin
                rd_req    = 1'b1;
                slot_push = go_fill_fifo;
                if (rd_ack) begin
                    beat_cnt_d = CNT_FULL;
                    state_d    = ST_DATA;
                end
            end

            ST_DATA: begin
                slot_push     = go_fill_fifo;
                rd_data_ready = !fifo_full;
                beat_acc      = rd_data_valid && !fifo_full;
                if (beat_acc) begin
                    if (beat_cnt_q != '0) begin
                        fifo_wr_en   = 1'b1;
                        fifo_wr_data = rd_data;
                        cnt_after    = beat_cnt_q - 1'b1;
                    end else begin
                        // Surplus beat: drained from the bus, not written.
                        err_set = 1'b1;
                    end
                end
                beat_cnt_d = cnt_after;
                if (rd_cmplt) begin
                    if (rd_error || (cnt_after != '0)) begin
                        err_set = 1'b1;
                    end
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                // The DONE cycle is the inter-burst gap; a held request is
                // dispatched straight from here so the gap stays one cycle.
                slot_push = go_fill_fifo;
                if (slot_vld) begin
                    slot_pop  = 1'b1;
                    rd_addr_d = align_word(slot_addr);
                    state_d   = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Setting a flag wins over a simultaneous clear.
        err_d = err_set      ? 1'b1 : (clr_status ? 1'b0 : err_q);
        ovr_d = slot_overrun ? 1'b1 : (clr_status ? 1'b0 : ovr_q);
    end

    always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
        if (Bus2IP_Reset) begin
            state_q    <= ST_IDLE;
            rd_addr_q  <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
            ovr_q      <= ovr_d;
        end
    end

    assign rd_addr        = rd_addr_q;
    assign rd_len         = LEN_BYTES;
    assign busy           = (state_q != ST_IDLE);
    assign err_sticky     = err_q;
    assign overrun_sticky = ovr_q;

endmodule

// File: tb/tb_ddr_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_ddr_burst_reader
//   Directed bench for ddr_burst_reader: single burst, back-to-back with a
//   queued request and an overrun, FIFO back-pressure, bus error, short and
//   long bursts, and asynchronous reset mid-burst.
// -----------------------------------------------------------------------------
module tb_ddr_burst_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        go_fill_fifo;
    logic [31:0] ddr_addr_to_read;
    logic        clr_status;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic [11:0] rd_len;
    logic        rd_ack;
    logic [31:0] rd_data;
    logic        rd_data_valid;
    logic        rd_data_ready;
    logic        rd_cmplt;
    logic        rd_error;
    logic        fifo_wr_en;
    logic [31:0] fifo_wr_data;
    logic        fifo_full;
    logic        busy;
    logic        err_sticky;
    logic        overrun_sticky;

    ddr_burst_reader #(
        .BURST_WORDS (64),
        .DATA_W      (32)
    ) dut (
        .Bus2IP_Clk       (clk),
        .Bus2IP_Reset     (rst),
        .go_fill_fifo     (go_fill_fifo),
        .ddr_addr_to_read (ddr_addr_to_read),
        .clr_status       (clr_status),
        .rd_req           (rd_req),
        .rd_addr          (rd_addr),
        .rd_len           (rd_len),
        .rd_ack           (rd_ack),
        .rd_data          (rd_data),
        .rd_data_valid    (rd_data_valid),
        .rd_data_ready    (rd_data_ready),
        .rd_cmplt         (rd_cmplt),
        .rd_error         (rd_error),
        .fifo_wr_en       (fifo_wr_en),
        .fifo_wr_data     (fifo_wr_data),
        .fifo_full        (fifo_full),
        .busy             (busy),
        .err_sticky       (err_sticky),
        .overrun_sticky   (overrun_sticky)
    );

    always #5 clk = ~clk;

    int          vec = 0;
    int          errs = 0;
    int          cyc = 0;
    int          req_rise_cyc = -1;
    int          cmplt_cyc = -1;
    logic        req_prev = 1'b0;
    logic [31:0] wq[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record FIFO writes and handshake timing mid-cycle.
    always @(negedge clk) begin
        if (fifo_wr_en) wq.push_back(fifo_wr_data);
        if (rd_req && !req_prev) req_rise_cyc = cyc;
        if (rd_cmplt && busy) cmplt_cyc = cyc;
        req_prev = rd_req;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // From IDLE: issue a request, acknowledge it in the first REQ cycle.
    task automatic start_burst(input logic [31:0] addr, input logic [31:0] exp_addr);
        wq.delete();
        go_fill_fifo     = 1'b1;
        ddr_addr_to_read = addr;
        next();
        go_fill_fifo     = 1'b0;
        ddr_addr_to_read = '0;
        rd_ack           = 1'b1;
        #1;
        chk("start_req", rd_req, 1);
        chk("start_addr", rd_addr, exp_addr);
        next();
        rd_ack = 1'b0;
    endtask

    // Present n beats base, base+1, ...; fifo_full is high for full_len
    // cycles starting at cycle full_at of this call.
    task automatic send_beats(input int n, input logic [31:0] base, input int full_at, input int full_len);
        int   i = 0;
        int   c = 0;
        logic acc;
        while (i < n && c < 400) begin
            rd_data_valid = 1'b1;
            rd_data       = base + i;
            fifo_full     = (c >= full_at) && (c < full_at + full_len);
            #1;
            acc = rd_data_ready;
            if (fifo_full) begin
                chk("ready_when_full", rd_data_ready, 0);
                chk("wr_when_full", fifo_wr_en, 0);
            end
            next();
            c++;
            if (acc) i++;
        end
        rd_data_valid = 1'b0;
        rd_data       = '0;
        fifo_full     = 1'b0;
        chk("beats_accepted", i, n);
    endtask

    task automatic end_burst(input logic err);
        rd_cmplt = 1'b1;
        rd_error = err;
        next();
        rd_cmplt = 1'b0;
        rd_error = 1'b0;
    endtask

    task automatic check_writes(input int n, input logic [31:0] base);
        chk("wr_count", wq.size(), n);
        for (int k = 0; k < wq.size() && k < n; k++) begin
            chk($sformatf("wr_data[%0d]", k), wq[k], base + k);
        end
        wq.delete();
    endtask

    initial begin
        rst              = 1'b0;
        go_fill_fifo     = 1'b0;
        ddr_addr_to_read = '0;
        clr_status       = 1'b0;
        rd_ack           = 1'b0;
        rd_data          = '0;
        rd_data_valid    = 1'b0;
        rd_cmplt         = 1'b0;
        rd_error         = 1'b0;
        fifo_full        = 1'b0;
        #1 rst = 1'b1;
        #1;
        // Reset state
        chk("rst_rd_req", rd_req, 0);
        chk("rst_ready", rd_data_ready, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_wr_data", fifo_wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_sticky, 0);
        chk("rst_ovr", overrun_sticky, 0);
        chk("rst_addr", rd_addr, 0);
        chk("rd_len", rd_len, 12'd256);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single burst, ack after three REQ cycles
        wq.delete();
        go_fill_fifo     = 1'b1;
        ddr_addr_to_read = 32'h1000_0003;
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_req", rd_req, 0);
        next();
        go_fill_fifo = 1'b0;
        #1;
        chk("req_n1", rd_req, 1);
        chk("addr_masked", rd_addr, 32'h1000_0000);
        chk("busy_req", busy, 1);
        next(); #1;
        chk("req_hold1", rd_req, 1);
        chk("addr_hold1", rd_addr, 32'h1000_0000);
        next(); #1;
        chk("req_hold2", rd_req, 1);
        chk("addr_hold2", rd_addr, 32'h1000_0000);
        next();
        rd_ack = 1'b1;
        #1;
        chk("req_at_ack", rd_req, 1);
        next();
        rd_ack = 1'b0;
        #1;
        chk("req_after_ack", rd_req, 0);
        chk("data_ready", rd_data_ready, 1);
        send_beats(64, 32'hA000_0000, 0, 0);
        rd_cmplt = 1'b1;
        #1;
        chk("busy_cmplt", busy, 1);
        next();
        rd_cmplt = 1'b0;
        #1;
        chk("busy_done", busy, 1);
        next(); #1;
        chk("busy_low_2", busy, 0);
        chk("single_err", err_sticky, 0);
        chk("single_ovr", overrun_sticky, 0);
        check_writes(64, 32'hA000_0000);

        // Back-to-back with a queued request
        start_burst(32'h2000_0000, 32'h2000_0000);
        send_beats(10, 32'hB000_0000, 0, 0);
        go_fill_fifo     = 1'b1;
        ddr_addr_to_read = 32'h1000_0100;
        next();
        go_fill_fifo = 1'b0;
        #1;
        chk("queued_no_ovr", overrun_sticky, 0);
        send_beats(54, 32'hB000_000A, 0, 0);
        end_burst(1'b0);
        #1;
        chk("gap_no_req", rd_req, 0);
        next(); #1;
        chk("req2_rise", rd_req, 1);
        chk("req2_addr", rd_addr, 32'h1000_0100);
        check_writes(64, 32'hB000_0000);
        chk("b2b_err", err_sticky, 0);
        next();
        chk("cmplt_to_req", req_rise_cyc - cmplt_cyc, 2);
        rd_ack = 1'b1;
        next();
        rd_ack           = 1'b0;
        go_fill_fifo     = 1'b1;
        ddr_addr_to_read = 32'h3000_0000;
        next();
        ddr_addr_to_read = 32'h4000_0000;
        next();
        go_fill_fifo     = 1'b0;
        ddr_addr_to_read = '0;
        #1;
        chk("overrun_set", overrun_sticky, 1);
        send_beats(64, 32'hC000_0000, 0, 0);
        end_burst(1'b0);
        check_writes(64, 32'hC000_0000);
        #1;
        chk("gap3_no_req", rd_req, 0);
        next(); #1;
        chk("req3_rise", rd_req, 1);
        chk("req3_addr", rd_addr, 32'h3000_0000);

        // Back-pressure: fifo_full for 10 cycles mid-burst
        next();
        rd_ack = 1'b1;
        next();
        rd_ack = 1'b0;
        send_beats(64, 32'hD000_0000, 20, 10);
        end_burst(1'b0);
        next(); #1;
        chk("dropped_not_run", busy, 0);
        check_writes(64, 32'hD000_0000);
        chk("bp_err", err_sticky, 0);
        clr_status = 1'b1;
        next();
        clr_status = 1'b0;
        #1;
        chk("ovr_cleared", overrun_sticky, 0);

        // Bus error after 20 beats
        start_burst(32'h5000_0000, 32'h5000_0000);
        send_beats(20, 32'hE000_0000, 0, 0);
        end_burst(1'b1);
        #1;
        chk("err_set", err_sticky, 1);
        next(); #1;
        chk("err_idle", busy, 0);
        check_writes(20, 32'hE000_0000);
        clr_status = 1'b1;
        next();
        clr_status = 1'b0;
        #1;
        chk("err_cleared", err_sticky, 0);
        start_burst(32'h5000_0040, 32'h5000_0040);
        send_beats(5, 32'hE100_0000, 0, 0);
        clr_status = 1'b1;
        end_burst(1'b1);
        clr_status = 1'b0;
        #1;
        chk("err_set_over_clr", err_sticky, 1);
        next();
        clr_status = 1'b1;
        next();
        clr_status = 1'b0;
        #1;
        chk("err_cleared2", err_sticky, 0);

        // Short burst: 63 beats
        start_burst(32'h6000_0000, 32'h6000_0000);
        send_beats(63, 32'hF000_0000, 0, 0);
        end_burst(1'b0);
        #1;
        chk("short_err", err_sticky, 1);
        check_writes(63, 32'hF000_0000);
        next();
        clr_status = 1'b1;
        next();
        clr_status = 1'b0;

        // Long burst: 65 beats
        start_burst(32'h6000_1000, 32'h6000_1000);
        send_beats(64, 32'hF100_0000, 0, 0);
        #1;
        chk("at_64_no_err", err_sticky, 0);
        send_beats(1, 32'hF100_0040, 0, 0);
        #1;
        chk("long_err", err_sticky, 1);
        end_burst(1'b0);
        check_writes(64, 32'hF100_0000);
        next();
        clr_status = 1'b1;
        next();
        clr_status = 1'b0;

        // Asynchronous reset mid-DATA with the slot full
        start_burst(32'h7000_0000, 32'h7000_0000);
        send_beats(10, 32'h7700_0000, 0, 0);
        go_fill_fifo     = 1'b1;
        ddr_addr_to_read = 32'h7100_0000;
        next();
        ddr_addr_to_read = 32'h7200_0000;
        next();
        go_fill_fifo     = 1'b0;
        ddr_addr_to_read = '0;
        #1;
        chk("pre_rst_ovr", overrun_sticky, 1);
        rd_data_valid = 1'b1;
        rd_data       = 32'h1234_5678;
        #1;
        chk("pre_rst_wr", fifo_wr_en, 1);
        rst = 1'b1;
        #1;
        chk("arst_req", rd_req, 0);
        chk("arst_ready", rd_data_ready, 0);
        chk("arst_wr_en", fifo_wr_en, 0);
        chk("arst_wr_data", fifo_wr_data, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ovr", overrun_sticky, 0);
        chk("arst_addr", rd_addr, 0);
        next();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            next(); #1;
            chk($sformatf("pending_lost[%0d]", k), busy, 0);
            chk($sformatf("idle_ready[%0d]", k), rd_data_ready, 0);
        end
        rd_data_valid = 1'b0;
        rd_data       = '0;
        next();
        start_burst(32'h8000_0004, 32'h8000_0004);
        send_beats(64, 32'h8800_0000, 0, 0);
        end_burst(1'b0);
        check_writes(64, 32'h8800_0000);
        next(); #1;
        chk("clean_idle", busy, 0);
        chk("clean_err", err_sticky, 0);
        chk("clean_ovr", overrun_sticky, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
